// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and Rcon arithmetic for the AES round sequencer.
// Pure definitions: no latency, no flow control.
// Imported by the sequencer top and the Rcon generator.
package aes_round_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADDKEY,
        ST_ROUND,
        ST_FINAL,
        ST_OUTPUT
    } aes_seq_state_t;

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake and datapath-control bundle between the engine/datapath and the sequencer.
// master = engine/datapath side, slave = sequencer side.
// Optional perf counters appear only when AES_SEQ_PERF_EN is defined.
interface aes_round_sequencer_if;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       load_o;
    logic       commit_o;
    logic       first_o;
    logic       last_o;
    logic       key_step_o;
    logic [7:0] rcon_o;
    logic [3:0] round_o;
    logic       busy_o;
`ifdef AES_SEQ_PERF_EN
    logic [31:0] perf_blocks_o;
    logic [31:0] perf_stall_o;

    modport master (
        output in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, load_o, commit_o, first_o, last_o,
        input  key_step_o, rcon_o, round_o, busy_o, perf_blocks_o, perf_stall_o
    );
    modport slave (
        input  in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, load_o, commit_o, first_o, last_o,
        output key_step_o, rcon_o, round_o, busy_o, perf_blocks_o, perf_stall_o
    );
`else
    modport master (
        output in_valid_i, out_ready_i,
        input  in_ready_o, out_valid_o, load_o, commit_o, first_o, last_o,
        input  key_step_o, rcon_o, round_o, busy_o
    );
    modport slave (
        input  in_valid_i, out_ready_i,
        output in_ready_o, out_valid_o, load_o, commit_o, first_o, last_o,
        output key_step_o, rcon_o, round_o, busy_o
    );
`endif
endinterface

// File: rtl/aes_round_sequencer_rcon_gen.sv
// Rcon register: init loads 8'h01, step advances by xtime; init has priority.
// Latency: new value visible the cycle after init/step.
// No flow control; steps only when told to.
module aes_rcon_gen
    import aes_round_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcon <= AES_RCON_INIT;
        end else if (init) begin
            rcon <= AES_RCON_INIT;
        end else if (step) begin
            rcon <= aes_xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences an iterative AES datapath: load, AddRoundKey, NR-1 rounds, final round (optional perf counters: AES_SEQ_PERF_EN).
// Latency: accept at t -> out_valid_o at t+3+NR*ROUND_LAT; back-to-back blocks at the same interval.
// Backpressure: result held in OUTPUT until out_ready_i; in_ready_o follows out_ready_i there.
module aes_round_sequencer
    import aes_round_sequencer_pkg::*;
#(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    aes_round_sequencer_if.slave bus
);

    localparam int              LW         = $clog2(ROUND_LAT + 1);
    localparam logic [LW-1:0]   LAT_LAST   = LW'(ROUND_LAT - 1);
    localparam logic [3:0]      ROUND_LAST = 4'(NR);

    aes_seq_state_t state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic           load, commit, first, last, key_step, in_ready, out_valid;
    logic [7:0]     rcon;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        lat_d     = lat_q;
        load      = 1'b0;
        commit    = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        key_step  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load    = 1'b1;
                round_d = '0;
                lat_d   = '0;
                state_d = ST_ADDKEY;
            end
            ST_ADDKEY: begin
                commit   = 1'b1;
                first    = 1'b1;
                key_step = 1'b1;
                round_d  = 4'd1;
                state_d  = (NR == 1) ? ST_FINAL : ST_ROUND;
            end
            ST_ROUND: begin
                if (lat_q == LAT_LAST) begin
                    commit   = 1'b1;
                    key_step = 1'b1;
                    round_d  = round_q + 4'd1;
                    lat_d    = '0;
                    if (round_q + 4'd1 == ROUND_LAST) state_d = ST_FINAL;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_FINAL: begin
                if (lat_q == LAT_LAST) begin
                    commit  = 1'b1;
                    last    = 1'b1;
                    lat_d   = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready_i;
                if (bus.out_ready_i) state_d = bus.in_valid_i ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear aborts the block: nothing reaches the datapath this cycle.
        if (clear) begin
            state_d   = ST_IDLE;
            round_d   = '0;
            lat_d     = '0;
            load      = 1'b0;
            commit    = 1'b0;
            first     = 1'b0;
            last      = 1'b0;
            key_step  = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (clear | load),
        .step    (key_step),
        .rcon    (rcon)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.load_o      = load;
    assign bus.commit_o    = commit;
    assign bus.first_o     = first;
    assign bus.last_o      = last;
    assign bus.key_step_o  = key_step;
    assign bus.rcon_o      = rcon;
    assign bus.round_o     = round_q;
    assign bus.busy_o      = (state_q != ST_IDLE);

`ifdef AES_SEQ_PERF_EN
    logic [31:0] perf_blocks_q, perf_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else if (clear) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else if (state_q == ST_OUTPUT) begin
            if (bus.out_ready_i) perf_blocks_q <= perf_blocks_q + 32'd1;
            else                 perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign bus.perf_blocks_o = perf_blocks_q;
    assign bus.perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: cycle table for one block plus stall, clear,
// back-to-back and ROUND_LAT=3 sequences.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, clr_a, clr_b;

    aes_round_sequencer_if ifa ();
    aes_round_sequencer_if ifb ();

    aes_round_sequencer #(.NR(10), .ROUND_LAT(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clr_a), .bus(ifa.slave)
    );
    aes_round_sequencer #(.NR(10), .ROUND_LAT(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clr_b), .bus(ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {load, commit, first, last, key_step, out_valid, in_ready, busy, round[3:0]}
    function automatic logic [11:0] mk(input bit ld, cm, fi, la, ks, ov, ir, bs, input int rnd);
        return {ld, cm, fi, la, ks, ov, ir, bs, rnd[3:0]};
    endfunction

    function automatic logic [11:0] obs_a();
        return {ifa.load_o, ifa.commit_o, ifa.first_o, ifa.last_o, ifa.key_step_o,
                ifa.out_valid_o, ifa.in_ready_o, ifa.busy_o, ifa.round_o};
    endfunction

    typedef struct {
        logic        in_valid;
        logic        out_ready;
        logic [11:0] exp;
    } vec_t;

    vec_t       tbl [15];
    logic [7:0] rcon_tab [10];

    int ri, n, cyc, nout, ncm, kcnt, tv, tlast, badgap;
    int t_out [3];
    int cm [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        // Cycle 0 is the IDLE handshake; out_valid expected 13 cycles later.
        for (int k = 0; k < 15; k++) begin
            tbl[k].in_valid  = (k == 0);
            tbl[k].out_ready = 1'b1;
            if (k == 0)       tbl[k].exp = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (k == 1)  tbl[k].exp = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (k == 2)  tbl[k].exp = mk(0, 1, 1, 0, 1, 0, 0, 1, 0);
            else if (k <= 11) tbl[k].exp = mk(0, 1, 0, 0, 1, 0, 0, 1, k - 2);
            else if (k == 12) tbl[k].exp = mk(0, 1, 0, 1, 0, 0, 0, 1, 10);
            else if (k == 13) tbl[k].exp = mk(0, 0, 0, 0, 0, 1, 1, 1, 10);
            else              tbl[k].exp = mk(0, 0, 0, 0, 0, 0, 1, 0, 10);
        end

        reset_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ifa.in_valid_i = 1'b0; ifa.out_ready_i = 1'b1;
        ifb.in_valid_i = 1'b0; ifb.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_outputs", obs_a(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        check("rst_a_rcon", ifa.rcon_o, 8'h01);
        check("rst_b_busy_ready", {ifb.busy_o, ifb.in_ready_o, ifb.out_valid_o, ifb.commit_o}, 4'b0100);
        step();
        reset_n = 1'b1;

        // Single block, cycle-by-cycle table
        ri = 0;
        for (int k = 0; k < 15; k++) begin
            ifa.in_valid_i  = tbl[k].in_valid;
            ifa.out_ready_i = tbl[k].out_ready;
            @(negedge clk);
            check($sformatf("vec%0d", k), obs_a(), tbl[k].exp);
            if (tbl[k].exp[7] && ri < 10) begin
                check($sformatf("rcon_step%0d", ri), ifa.rcon_o, rcon_tab[ri]);
                ri++;
            end
            step();
        end

        // Output stall for 5 cycles
        clr_a = 1'b1; step(); clr_a = 1'b0;
        ifa.out_ready_i = 1'b0; ifa.in_valid_i = 1'b1;
        step();
        ifa.in_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ifa.out_valid_o && n < 40) begin
            step(); @(negedge clk); n++;
        end
        check("stall_out_valid_reached", ifa.out_valid_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i), {ifa.out_valid_o, ifa.in_ready_o, ifa.busy_o}, 3'b101);
            step(); @(negedge clk);
        end
`ifdef AES_SEQ_PERF_EN
        check("perf_stall", ifa.perf_stall_o, 32'd5);
`endif
        check("stall_still_valid", ifa.out_valid_o, 1'b1);
        ifa.out_ready_i = 1'b1;
        step(); @(negedge clk);
        check("stall_release_idle", {ifa.out_valid_o, ifa.in_ready_o, ifa.busy_o}, 3'b010);

        // Clear during round 5
        step();
        ifa.in_valid_i = 1'b1;
        step();
        ifa.in_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (ifa.round_o != 4'd5 && n < 20) begin
            step(); @(negedge clk); n++;
        end
        check("clr_round5_reached", ifa.round_o, 4'd5);
        clr_a = 1'b1;
        #1;
        check("clr_no_commit", {ifa.commit_o, ifa.key_step_o, ifa.load_o}, 3'b000);
        step();
        clr_a = 1'b0;
        @(negedge clk);
        check("clr_idle", {ifa.busy_o, ifa.in_ready_o, ifa.out_valid_o, ifa.round_o}, {3'b010, 4'd0});
        step();
        ifa.in_valid_i = 1'b1;
        step();
        ifa.in_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ifa.key_step_o && n < 10) begin
            step(); @(negedge clk); n++;
        end
        check("clr_next_rcon0", {ifa.key_step_o, ifa.first_o, ifa.rcon_o}, {2'b11, 8'h01});
        step(); @(negedge clk);
        check("clr_next_rcon1", {ifa.key_step_o, ifa.rcon_o}, {1'b1, 8'h02});
        n = 0;
        while (!ifa.out_valid_o && n < 40) begin
            step(); @(negedge clk); n++;
        end
        check("clr_next_done", ifa.out_valid_o, 1'b1);
        step();

        // Back-to-back with in_valid held high
        clr_a = 1'b1; step(); clr_a = 1'b0;
        ifa.in_valid_i = 1'b1; ifa.out_ready_i = 1'b1;
        cyc = 0; nout = 0;
        while (nout < 3 && cyc < 100) begin
            @(negedge clk);
            if (ifa.out_valid_o) begin
                t_out[nout] = cyc;
                nout++;
                if (nout == 3) ifa.in_valid_i = 1'b0;
            end
            step();
            cyc++;
        end
        check("b2b_count", nout, 3);
        check("b2b_first", t_out[0], 13);
        check("b2b_second", t_out[1], 26);
        check("b2b_third", t_out[2], 39);
`ifdef AES_SEQ_PERF_EN
        check("perf_blocks", ifa.perf_blocks_o, 32'd3);
`endif
        @(negedge clk);
        check("b2b_idle", {ifa.busy_o, ifa.in_ready_o}, 2'b01);

        // ROUND_LAT = 3 instance
        step();
        ifb.in_valid_i = 1'b1;
        step();
        ifb.in_valid_i = 1'b0;
        cyc = 1; ncm = 0; kcnt = 0; tv = -1; tlast = -1;
        while (cyc < 60) begin
            @(negedge clk);
            if (ifb.commit_o) begin
                if (ncm < 16) cm[ncm] = cyc;
                ncm++;
            end
            if (ifb.key_step_o) kcnt++;
            if (ifb.last_o) tlast = cyc;
            if (ifb.out_valid_o) begin
                tv = cyc;
                break;
            end
            step();
            cyc++;
        end
        check("lat3_out_valid_cycle", tv, 33);
        check("lat3_commits", ncm, 11);
        check("lat3_key_steps", kcnt, 10);
        check("lat3_last_cycle", tlast, 32);
        check("lat3_first_commit", cm[0], 2);
        badgap = 0;
        for (int i = 1; i < 11 && i < ncm && i < 16; i++)
            if (cm[i] - cm[i-1] != 3) badgap++;
        check("lat3_commit_gaps", badgap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
